// File: rtl/debug_pkg.sv
// Shared constants for the debug-kit run/step controller: FSM state codes,
// state width and the default debounce length for a 50 MHz board clock.
package debug_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_HALT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_STEP  = 2'd1;
    localparam logic [STATE_W-1:0] ST_BURST = 2'd2;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd3;

    localparam int DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/debug_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-sample debounce
// and a one-clock pulse on each accepted press (0->1 of the accepted level).
module btn_debounce
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DB_W            = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic step_req
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic            level_d_r;
    logic [DB_W-1:0] cnt_r;
    logic            step_req_r;

    // Synchronize, count consecutive disagreeing samples, and flag the accepted rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            level_r    <= 1'b0;
            level_d_r  <= 1'b0;
            cnt_r      <= {DB_W{1'b0}};
            step_req_r <= 1'b0;
        end else begin
            sync1_r   <= btn;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            // A single agreeing sample restarts the count from zero.
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= {DB_W{1'b0}};
                end else begin
                    cnt_r   <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= {DB_W{1'b0}};
            end
            step_req_r <= level_r & ~level_d_r;
        end
    end

    assign step_req = step_req_r;

endmodule

// File: rtl/debug_step_ctrl.sv
// Run/step controller producing the CPU clock enable from board controls:
// halt, single step, N-cycle burst, free run and a PC breakpoint.
// cycle_cnt, ctrl_state and bp_hit feed the seven-segment debug mux.
module debug_step_ctrl
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DB_W            = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_step,
    input  logic               run_sw,
    input  logic               burst_sw,
    input  logic [7:0]         burst_len,
    input  logic               bp_en,
    input  logic [31:0]        bp_addr,
    input  logic [31:0]        pc,
    output logic               cpu_ce,
    output logic               halted,
    output logic               bp_hit,
    output logic [31:0]        cycle_cnt,
    output logic [STATE_W-1:0] ctrl_state
);

    logic               step_req_s;
    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nxt_s;
    logic [7:0]         remaining_r;
    logic               first_cycle_r;
    logic               bp_hit_r;
    logic [31:0]        cycle_cnt_r;
    logic               bp_stop_s;
    logic               cpu_ce_s;
    logic               load_burst_s;
    logic               clr_bp_s;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_btn_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_step),
        .step_req (step_req_s)
    );

    // The first cycle after entering RUN/BURST is never trapped, so resuming
    // at the breakpoint PC makes progress.
    assign bp_stop_s = bp_en & (pc == bp_addr)
                     & ((state_r == ST_RUN) | (state_r == ST_BURST))
                     & ~first_cycle_r;

    // Clock-enable gate: reset, breakpoint and a dropped run switch all cut it in the same cycle.
    always_comb begin
        cpu_ce_s = 1'b0;
        if (rst || bp_stop_s || (state_r == ST_HALT)) begin
            cpu_ce_s = 1'b0;
        end else if ((state_r == ST_RUN) && !run_sw) begin
            cpu_ce_s = 1'b0;
        end else begin
            cpu_ce_s = 1'b1;
        end
    end

    // Next-state logic; a step press in HALT outranks the run switch.
    always_comb begin
        state_nxt_s  = state_r;
        load_burst_s = 1'b0;
        clr_bp_s     = 1'b0;
        case (state_r)
            ST_HALT: begin
                if (step_req_s) begin
                    clr_bp_s = 1'b1;
                    if (burst_sw && (burst_len != 8'd0)) begin
                        state_nxt_s  = ST_BURST;
                        load_burst_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_STEP;
                    end
                end else if (run_sw && !bp_hit_r) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_STEP: begin
                state_nxt_s = ST_HALT;
            end
            ST_BURST: begin
                if (bp_stop_s || (remaining_r == 8'd1)) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            ST_RUN: begin
                if (bp_stop_s || !run_sw) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_HALT;
            end
        endcase
    end

    // State, burst counter, first-cycle mask, sticky breakpoint flag and enabled-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_HALT;
            remaining_r   <= 8'd0;
            first_cycle_r <= 1'b0;
            bp_hit_r      <= 1'b0;
            cycle_cnt_r   <= 32'd0;
        end else begin
            state_r <= state_nxt_s;

            if (load_burst_s) begin
                remaining_r <= burst_len;
            end else if ((state_r == ST_BURST) && cpu_ce_s) begin
                remaining_r <= remaining_r - 8'd1;
            end else begin
                remaining_r <= remaining_r;
            end

            first_cycle_r <= (state_r == ST_HALT) &&
                             ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_BURST));

            if (bp_stop_s) begin
                bp_hit_r <= 1'b1;
            end else if (clr_bp_s) begin
                bp_hit_r <= 1'b0;
            end else begin
                bp_hit_r <= bp_hit_r;
            end

            if (cpu_ce_s) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
        end
    end

    assign cpu_ce     = cpu_ce_s;
    assign halted     = (state_r == ST_HALT);
    assign bp_hit     = bp_hit_r;
    assign cycle_cnt  = cycle_cnt_r;
    assign ctrl_state = state_r;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl with a 4-sample debounce.
// Each expected enabled CPU cycle (pc, cycle_cnt before increment, state) is
// queued when stimulus is driven; a negedge monitor pops one per cpu_ce=1.
module tb_debug_step_ctrl;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step;
    logic        run_sw;
    logic        burst_sw;
    logic [7:0]  burst_len;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_ce;
    logic        halted;
    logic        bp_hit;
    logic [31:0] cycle_cnt;
    logic [1:0]  ctrl_state;

    logic        pc_auto;
    logic        pc_clr;
    logic [31:0] pc_fixed;
    logic [31:0] exec_pc;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [1:0]  st;
    } exp_t;
    exp_t exp_q[$];

    debug_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DB_W            (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .run_sw     (run_sw),
        .burst_sw   (burst_sw),
        .burst_len  (burst_len),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_ce     (cpu_ce),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .cycle_cnt  (cycle_cnt),
        .ctrl_state (ctrl_state)
    );

    always #5 clk = ~clk;

    // Tiny CPU stand-in: PC advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (pc_clr) exec_pc <= 32'd0;
        else if (cpu_ce === 1'b1) exec_pc <= exec_pc + 32'd4;
    end

    assign pc = pc_auto ? exec_pc : pc_fixed;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] c, input logic [1:0] s);
        exp_q.push_back('{pc: p, cnt: c, st: s});
    endtask

    // Scoreboard monitor: every enabled cycle must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_ce === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_ce", {31'd0, cpu_ce}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("ce_pc",    pc,                 e.pc);
                check_val("ce_cnt",   cycle_cnt,          e.cnt);
                check_val("ce_state", {30'd0, ctrl_state}, {30'd0, e.st});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: enable must first appear 8 edges later (N+3 debounce, +1 FSM).
    task automatic press();
        int k;
        k = 0;
        btn_step = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (cpu_ce === 1'b1) begin
                k = i;
                break;
            end
        end
        check_val("press_latency", k, 32'd8);
    endtask

    task automatic release_btn();
        btn_step = 1'b0;
        cyc(10);
    endtask

    task automatic wait_run(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (ctrl_state == ST_RUN) begin
                seen = 1'b1;
                break;
            end
        end
        check_val(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic [31:0] cnt, input logic hit);
        @(negedge clk);
        check_val({tag, "_state"}, {30'd0, ctrl_state}, {30'd0, ST_HALT});
        check_val({tag, "_halted"}, {31'd0, halted}, 32'd1);
        check_val({tag, "_cnt"}, cycle_cnt, cnt);
        check_val({tag, "_bphit"}, {31'd0, bp_hit}, {31'd0, hit});
        check_val({tag, "_qleft"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; btn_step = 1'b0; run_sw = 1'b0; burst_sw = 1'b0;
        burst_len = 8'd0; bp_en = 1'b0; bp_addr = 32'd0;
        pc_auto = 1'b0; pc_clr = 1'b1; pc_fixed = 32'h100;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ce", {31'd0, cpu_ce}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; pc_clr = 1'b0;
        check_idle("reset", 32'd0, 1'b0);
        cyc(1);

        // Bouncy press, then held: exactly one STEP cycle.
        for (int i = 0; i < 10; i++) begin
            btn_step = ~btn_step;
            cyc(2);
        end
        push_exp(32'h100, 32'd0, ST_STEP);
        press();
        cyc(4);
        release_btn();
        check_idle("bounce", 32'd1, 1'b0);
        cyc(1);

        // Burst of 5 enabled cycles.
        burst_sw = 1'b1; burst_len = 8'd5;
        for (int i = 0; i < 5; i++) push_exp(32'h100, 32'd1 + i, ST_BURST);
        press();
        cyc(10);
        release_btn();
        check_idle("burst5", 32'd6, 1'b0);
        cyc(1);

        // Burst length 0 degrades to a single step.
        burst_len = 8'd0;
        push_exp(32'h100, 32'd6, ST_STEP);
        press();
        cyc(4);
        release_btn();
        check_idle("burst0", 32'd7, 1'b0);
        cyc(1);

        // Free run for 10 enabled cycles, then stop.
        burst_sw = 1'b0;
        for (int i = 0; i < 10; i++) push_exp(32'h100, 32'd7 + i, ST_RUN);
        run_sw = 1'b1;
        cyc(11);
        run_sw = 1'b0;
        @(negedge clk);
        check_val("runoff_ce", {31'd0, cpu_ce}, 32'd0);
        check_val("runoff_state", {30'd0, ctrl_state}, {30'd0, ST_RUN});
        cyc(1);
        check_idle("runstop", 32'd17, 1'b0);
        cyc(1);

        // Breakpoint at 0x1C while running from PC 0.
        pc_clr = 1'b1; cyc(1); pc_clr = 1'b0;
        pc_auto = 1'b1; bp_en = 1'b1; bp_addr = 32'h1C;
        for (int i = 0; i < 7; i++) push_exp(32'd4 * i, 32'd17 + i, ST_RUN);
        run_sw = 1'b1;
        cyc(14);
        check_idle("bp", 32'd24, 1'b1);
        check_val("bp_pc", pc, 32'h1C);
        cyc(1);

        // Resume: one STEP at 0x1C, bp_hit cleared, back to RUN.
        push_exp(32'h1C, 32'd24, ST_STEP);
        press();
        wait_run("resume_run");
        run_sw = 1'b0;
        @(negedge clk);
        check_val("resume_bphit", {31'd0, bp_hit}, 32'd0);
        cyc(2);
        release_btn();
        check_idle("resume", 32'd25, 1'b0);
        check_val("resume_pc", pc, 32'h20);
        cyc(1);

        // Burst starting at the breakpoint PC: first cycle masked, second trapped.
        pc_auto = 1'b0; pc_fixed = 32'h1C;
        burst_sw = 1'b1; burst_len = 8'd3;
        push_exp(32'h1C, 32'd25, ST_BURST);
        press();
        cyc(6);
        release_btn();
        check_idle("bpburst", 32'd26, 1'b1);
        cyc(1);

        // Reset in the middle of RUN.
        bp_en = 1'b0; burst_sw = 1'b0; run_sw = 1'b1;
        push_exp(32'h1C, 32'd26, ST_STEP);
        for (int i = 0; i < 3; i++) push_exp(32'h1C, 32'd27 + i, ST_RUN);
        press();
        wait_run("pre_rst_run");
        cyc(3);
        rst = 1'b1; run_sw = 1'b0; btn_step = 1'b0;
        @(negedge clk);
        check_val("midrun_rst_ce", {31'd0, cpu_ce}, 32'd0);
        cyc(1);
        rst = 1'b0;
        check_idle("midrun_rst", 32'd0, 1'b0);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
